// File: rtl/character_sprite_fetch_if.sv
// Slot table read port: the fetch block drives slot_sel and the table answers combinationally.
interface character_sprite_fetch_if #(
  parameter int SLOTS = 8
);
  localparam int SEL_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [SEL_W-1:0] slot_sel;
  logic [9:0]       slot_x;
  logic [9:0]       slot_y;
  logic [2:0]       slot_type;
  logic [3:0]       slot_state;
  logic             slot_army;

  modport master (
    output slot_sel,
    input  slot_x, slot_y, slot_type, slot_state, slot_army
  );

  modport slave (
    input  slot_sel,
    output slot_x, slot_y, slot_type, slot_state, slot_army
  );
endinterface

// File: rtl/character_sprite_fetch.sv
// Sprite ROM address generator: an hblank slot scan builds the next line's character list, and
// active video picks the covering character per pixel. Build macro CHAR_MIRROR_EN mirrors enemies.
module character_sprite_fetch #(
  parameter int SLOTS    = 8,
  parameter int LINE_MAX = 4,
  parameter int SPR_W    = 64,
  parameter int SPR_H    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               h_cnt,
  input  logic [9:0]               v_cnt,
  character_sprite_fetch_if.master slot,
  output logic                     pix_hit,
  output logic                     pix_army,
  output logic [2:0]               pix_type,
  output logic [12:0]              pix_addr,
  output logic                     scan_busy,
  output logic                     line_ovf
);
  localparam int SEL_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int CNT_W = $clog2(LINE_MAX + 1);

  localparam logic [9:0] H_ACT  = 10'd640;
  localparam logic [9:0] V_ACT  = 10'd480;
  localparam logic [9:0] V_LAST = 10'd524;

`ifdef CHAR_MIRROR_EN
  localparam logic MIRROR_ENEMY = 1'b1;
`else
  localparam logic MIRROR_ENEMY = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [9:0]       prev_h_q;
  logic [SEL_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [9:0]       tgt_q;

  logic [LINE_MAX-1:0] ent_vld_q;
  logic [LINE_MAX-1:0] ent_army_q;
  logic [9:0]          ent_x_q    [LINE_MAX];
  logic [ROW_W-1:0]    ent_row_q  [LINE_MAX];
  logic [2:0]          ent_type_q [LINE_MAX];

  logic start, enter, slot_hit;

  logic        active_p0, vld_p0, army_p0;
  logic [2:0]  type_p0;
  logic [12:0] addr_p0;

  logic        vld_p1, army_p1;
  logic [2:0]  type_p1;
  logic [12:0] addr_p1;

  // Sprite words are stored row-major with power-of-two width, so the address is a plain concat.
  function automatic logic [12:0] make_addr(input logic [ROW_W-1:0] row,
                                            input logic [COL_W-1:0] col,
                                            input logic             mirror);
    logic [COL_W-1:0] c;
    c = mirror ? ~col : col;
    return 13'({row, c});
  endfunction

  assign start    = (h_cnt == H_ACT) && (prev_h_q != H_ACT);
  assign enter    = (state_q == IDLE) && start;
  assign slot_hit = (state_q == SCAN) && (slot.slot_state != 4'd0) &&
                    (tgt_q >= slot.slot_y) && (32'(tgt_q - slot.slot_y) < SPR_H);

  assign slot.slot_sel = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    scan_busy = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        scan_busy = 1'b1;
        if (idx_q == SEL_W'(SLOTS - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // List control: the scan index wraps back to 0 on the last slot, leaving slot_sel at 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_h_q  <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ent_vld_q <= '0;
    end else begin
      prev_h_q <= h_cnt;
      if (enter) begin
        idx_q     <= '0;
        cnt_q     <= '0;
        ovf_q     <= 1'b0;
        ent_vld_q <= '0;
      end else if (state_q == SCAN) begin
        idx_q <= idx_q + SEL_W'(1);
        if (slot_hit) begin
          if (cnt_q == CNT_W'(LINE_MAX)) begin
            ovf_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            for (int i = 0; i < LINE_MAX; i++) begin
              if (cnt_q == CNT_W'(i)) begin
                ent_vld_q[i] <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // List payload only matters where ent_vld_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (enter) begin
      tgt_q <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    if (slot_hit) begin
      for (int i = 0; i < LINE_MAX; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          ent_x_q[i]    <= slot.slot_x;
          ent_row_q[i]  <= ROW_W'(tgt_q - slot.slot_y);
          ent_type_q[i] <= slot.slot_type;
          ent_army_q[i] <= slot.slot_army;
        end
      end
    end
  end

  // Stage p0: parallel match of the current pixel against every valid entry, lowest index wins.
  assign active_p0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  always_comb begin
    vld_p0  = 1'b0;
    army_p0 = 1'b0;
    type_p0 = '0;
    addr_p0 = '0;
    for (int i = LINE_MAX - 1; i >= 0; i--) begin
      if (active_p0 && ent_vld_q[i] && (h_cnt >= ent_x_q[i]) &&
          (32'(h_cnt - ent_x_q[i]) < SPR_W)) begin
        vld_p0  = 1'b1;
        army_p0 = ent_army_q[i];
        type_p0 = ent_type_q[i];
        addr_p0 = make_addr(ent_row_q[i], COL_W'(h_cnt - ent_x_q[i]),
                            MIRROR_ENEMY & ~ent_army_q[i]);
      end
    end
  end

  // Stage p1: registered ROM request, one clk behind the raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      army_p1 <= 1'b0;
      type_p1 <= '0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      army_p1 <= army_p0;
      type_p1 <= type_p0;
      addr_p1 <= addr_p0;
    end
  end

  assign pix_hit  = vld_p1;
  assign pix_army = army_p1;
  assign pix_type = type_p1;
  assign pix_addr = addr_p1;
  assign line_ovf = ovf_q;

endmodule

// File: tb/tb_character_sprite_fetch.sv
// Directed and randomized bench for character_sprite_fetch against a slot-table reference model.
module tb_character_sprite_fetch;
  localparam int SLOTS    = 8;
  localparam int LINE_MAX = 4;
  localparam int SPR_W    = 64;
  localparam int SPR_H    = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  h_cnt = 10'd700;
  logic [9:0]  v_cnt = 10'd0;
  logic        pix_hit, pix_army, scan_busy, line_ovf;
  logic [2:0]  pix_type;
  logic [12:0] pix_addr;

  logic [9:0] sx     [SLOTS];
  logic [9:0] sy     [SLOTS];
  logic [2:0] stype  [SLOTS];
  logic [3:0] sstate [SLOTS];
  logic       sarmy  [SLOTS];

  int checks = 0;
  int errors = 0;
  bit list_ok = 1'b0;

  always #5 clk = ~clk;

  character_sprite_fetch_if #(.SLOTS(SLOTS)) sif ();

  assign sif.slot_x     = sx[sif.slot_sel];
  assign sif.slot_y     = sy[sif.slot_sel];
  assign sif.slot_type  = stype[sif.slot_sel];
  assign sif.slot_state = sstate[sif.slot_sel];
  assign sif.slot_army  = sarmy[sif.slot_sel];

  character_sprite_fetch #(
    .SLOTS(SLOTS), .LINE_MAX(LINE_MAX), .SPR_W(SPR_W), .SPR_H(SPR_H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .slot(sif),
    .pix_hit(pix_hit), .pix_army(pix_army), .pix_type(pix_type), .pix_addr(pix_addr),
    .scan_busy(scan_busy), .line_ovf(line_ovf)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Number of occupied slots whose bounding box covers line v.
  function automatic int hits_on(input int v);
    int n = 0;
    for (int s = 0; s < SLOTS; s++)
      if (sstate[s] != 4'd0 && v >= int'(sy[s]) && v - int'(sy[s]) < SPR_H) n++;
    return n;
  endfunction

  // Only the first LINE_MAX covering slots (slot order) are visible; the first one covering h wins.
  function automatic void model_pix(input int h, input int v, output logic eh, output logic ea,
                                    output logic [2:0] et, output logic [12:0] ed);
    int n, col, row;
    eh = 1'b0; ea = 1'b0; et = 3'd0; ed = 13'd0;
    if (!list_ok || h >= 640 || v >= 480) return;
    n = 0;
    for (int s = 0; s < SLOTS; s++) begin
      if (sstate[s] != 4'd0 && v >= int'(sy[s]) && v - int'(sy[s]) < SPR_H) begin
        if (n < LINE_MAX && !eh && h >= int'(sx[s]) && h - int'(sx[s]) < SPR_W) begin
          col = h - int'(sx[s]);
          row = v - int'(sy[s]);
`ifdef CHAR_MIRROR_EN
          if (!sarmy[s]) col = SPR_W - 1 - col;
`endif
          eh = 1'b1;
          ea = sarmy[s];
          et = stype[s];
          ed = 13'(row * SPR_W + col);
        end
        n++;
      end
    end
  endfunction

  task automatic clear_slots();
    for (int s = 0; s < SLOTS; s++) begin
      sx[s] = 10'd0; sy[s] = 10'd0; stype[s] = 3'd0; sstate[s] = 4'd0; sarmy[s] = 1'b0;
    end
  endtask

  task automatic set_slot(input int s, input int x, input int y, input int t, input int a, input int st);
    sx[s] = 10'(x); sy[s] = 10'(y); stype[s] = 3'(t); sarmy[s] = 1'(a); sstate[s] = 4'(st);
  endtask

  // Runs the hblank scan that builds the list for the given line, then checks scan length and overflow.
  task automatic do_scan(input string tag, input int line);
    int busy = 0;
    v_cnt = (line == 0) ? 10'd524 : 10'(line - 1);
    h_cnt = 10'd639;
    @(posedge clk); #1;
    h_cnt = 10'd640;
    for (int c = 0; c < SLOTS + 4; c++) begin
      @(posedge clk); #1;
      if (scan_busy === 1'b1) busy++;
    end
    check({tag, "_scan_len"}, busy, SLOTS);
    check({tag, "_ovf"}, line_ovf, (hits_on(line) > LINE_MAX) ? 1 : 0);
    h_cnt = 10'd700;
    list_ok = 1'b1;
  endtask

  task automatic check_pix(input string tag, input int h, input int v);
    logic eh, ea;
    logic [2:0] et;
    logic [12:0] ed;
    model_pix(h, v, eh, ea, et, ed);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    @(posedge clk); #1;
    check({tag, "_hit"}, pix_hit, eh);
    check({tag, "_army"}, pix_army, ea);
    check({tag, "_type"}, pix_type, et);
    check({tag, "_addr"}, pix_addr, ed);
  endtask

  initial begin
    int line, h, hits;
    clear_slots();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_hit", pix_hit, 0);
    check("rst_army", pix_army, 0);
    check("rst_type", pix_type, 0);
    check("rst_addr", pix_addr, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_ovf", line_ovf, 0);
    check("rst_sel", sif.slot_sel, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single character
    set_slot(2, 100, 200, 3, 1, 1);
    do_scan("single", 209);
    h_cnt = 10'd105; v_cnt = 10'd209;
    @(posedge clk); #1;
    check("single_hit", pix_hit, 1);
    check("single_army", pix_army, 1);
    check("single_type", pix_type, 3);
    check("single_addr", pix_addr, 581);
    check_pix("single_left", 99, 209);
    check_pix("single_right", 163, 209);
    check_pix("single_edge", 164, 209);
    check_pix("single_vblank", 105, 490);

    // Overlap priority
    clear_slots();
    set_slot(0, 280, 40, 1, 1, 1);
    set_slot(5, 290, 30, 5, 0, 3);
    do_scan("ovl", 50);
    h_cnt = 10'd300; v_cnt = 10'd50;
    @(posedge clk); #1;
    check("ovl_type0", pix_type, 1);
    check("ovl_addr0", pix_addr, 660);
    sstate[0] = 4'd0;
    do_scan("ovl_rescan", 50);
    check_pix("ovl_slot5", 300, 50);
    h_cnt = 10'd300; v_cnt = 10'd50;
    @(posedge clk); #1;
    check("ovl_type5", pix_type, 5);

    // Line overflow
    clear_slots();
    for (int s = 0; s < 6; s++) set_slot(s, 10 + 70 * s, 100 + s, s, s % 2, 1);
    do_scan("ovf", 120);
    check("ovf_level", line_ovf, 1);
    for (int s = 0; s < 6; s++) check_pix($sformatf("ovf_s%0d", s), 15 + 70 * s, 120);
    check("ovf_hold", line_ovf, 1);
    do_scan("ovf_clear", 400);
    check("ovf_cleared", line_ovf, 0);

    // Frame wrap and edges
    clear_slots();
    set_slot(1, 600, 0, 2, 1, 2);
    set_slot(3, 0, 470, 4, 0, 1);
    do_scan("wrap", 0);
    check_pix("wrap_y470", 10, 0);
    h_cnt = 10'd639; v_cnt = 10'd0;
    @(posedge clk); #1;
    check("edge_hit", pix_hit, 1);
    check("edge_addr", pix_addr, 39);
    check_pix("edge_x600", 600, 0);
    check_pix("edge_h640", 640, 0);
    h_cnt = 10'd700;
    repeat (SLOTS + 2) @(posedge clk);
    #1;

`ifdef CHAR_MIRROR_EN
    clear_slots();
    set_slot(4, 0, 0, 6, 0, 1);
    do_scan("mirror_enemy", 0);
    h_cnt = 10'd0; v_cnt = 10'd0;
    @(posedge clk); #1;
    check("mirror_enemy_addr", pix_addr, 63);
    sarmy[4] = 1'b1;
    do_scan("mirror_army", 0);
    h_cnt = 10'd0; v_cnt = 10'd0;
    @(posedge clk); #1;
    check("mirror_army_addr", pix_addr, 0);
`endif

    // Randomized tables
    for (int it = 0; it < 12; it++) begin
      line = $urandom_range(0, 479);
      for (int s = 0; s < SLOTS; s++)
        set_slot(s, $urandom_range(0, 660), ((line >= 40) ? line - 40 : 0) + $urandom_range(0, 60),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3));
      do_scan($sformatf("rnd%0d", it), line);
      for (int s = 0; s < SLOTS; s++) begin
        h = int'(sx[s]) + 3;
        if (h == 640) h = 641;
        check_pix($sformatf("rnd%0d_s%0d", it, s), h, line);
      end
      for (int k = 0; k < 4; k++) begin
        h = $urandom_range(0, 700);
        if (h == 640) h = 641;
        check_pix($sformatf("rnd%0d_p%0d", it, k), h, line);
      end
    end

    // Reset during the scan
    clear_slots();
    for (int s = 0; s < SLOTS; s++) set_slot(s, 80 * s, 280, 1, 1, 1);
    v_cnt = 10'd299;
    h_cnt = 10'd639;
    @(posedge clk); #1;
    h_cnt = 10'd640;
    for (int c = 0; c < 4 && scan_busy !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    check("midrst_busy_before", scan_busy, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", scan_busy, 0);
    check("midrst_hit", pix_hit, 0);
    check("midrst_addr", pix_addr, 0);
    check("midrst_ovf", line_ovf, 0);
    check("midrst_sel", sif.slot_sel, 0);
    h_cnt = 10'd700;
    list_ok = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    hits = 0;
    v_cnt = 10'd300;
    for (int x = 0; x < 640; x++) begin
      h_cnt = 10'(x);
      @(posedge clk); #1;
      if (pix_hit !== 1'b0) hits++;
    end
    check("midrst_line_hits", hits, 0);
    h_cnt = 10'd700;
    @(posedge clk); #1;
    do_scan("recover", 300);
    check_pix("recover_pix", 85, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
